// File: rtl/reg_file_wb.sv
// Write-back register file: two combinational read ports with optional write->read
// bypass, a registered debug read port, and a committed-write counter.
`timescale 1ns/10ps
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 is the hard-wired zero register and has no storage.
    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
    logic [31:0]       wr_count_q, wr_count_d;
    logic              commit;
    logic              byp_en;

    assign commit = we && (waddr != '0);
    // Bypass is suppressed while reset is held so reads stay at zero.
    assign byp_en = (BYPASS != 0) && rst_n && we;

    always_comb begin
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        dbg_data_d = '0;
        if (dbg_addr != '0) begin
            dbg_data_d = regs_q[dbg_addr];
        end
        if (commit) begin
            regs_d[waddr] = wdata;
            wr_count_d    = wr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            dbg_data_q <= '0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            dbg_data_q <= dbg_data_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rst_n && (raddr1 != '0)) begin
            if (byp_en && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs_q[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst_n && (raddr2 != '0)) begin
            if (byp_en && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs_q[raddr2];
            end
        end
    end

    assign dbg_data = dbg_data_q;
    assign wr_count = wr_count_q;

endmodule
